divu_p6y3: RTL
==============

# divu_p6y3

Sequential unsigned restoring divider, the inverse of the mulu_x3y3 combinational multiplier. Divides a 6-bit dividend `p` by a 3-bit divisor `y` and returns a 6-bit quotient and 3-bit remainder. It runs one quotient bit per clock under a start/busy/rdy handshake. It sits beside mulu_x3y3 in the arithmetic tile and shares its operand widths (`P_WIDTH`, `Y_WIDTH` from config.vh), so a bench can check x·y → p → (q, r) round trips.

## Interface
Parameters:
- `P_WIDTH`, 6: dividend and quotient width.
- `Y_WIDTH`, 3: divisor and remainder width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous active-high reset. One clock; reset is synchronous and active-high.
- `start`  in  1  request a division; sampled only when `busy`=0.
- `p`  in  P_WIDTH  dividend, captured on the accepting edge.
- `y`  in  Y_WIDTH  divisor, captured on the accepting edge.
- `q`  out  P_WIDTH  quotient, registered.
- `r`  out  Y_WIDTH  remainder, registered.
- `busy`  out  1  division in progress.
- `rdy`  out  1  result valid. Level signal, held until the next accepted `start` or `rst`.
- `dz`  out  1  divide-by-zero flag. Present only with `DIVU_DIV0_EN`.

## Operation
- States:
  - IDLE: after reset, no result yet.
  - RUN: iterating.
  - DONE: result valid.
- IDLE/DONE with `start`=1 → RUN:
  - latch `y` into the divisor register and `p` into the dividend shift register;
  - clear the partial remainder `rem` (Y_WIDTH+1 bits) and the step counter;
  - `rdy` drops.
- RUN, each cycle:
  - `rem` ← {rem[Y_WIDTH-1:0], dividend MSB}, then shift the dividend left;
  - if `rem` ≥ divisor: `rem` ← `rem` − divisor and shift a 1 into the quotient register, else shift a 0;
  - increment the counter.
- After `P_WIDTH` steps → DONE: `q` ← quotient register, `r` ← rem[Y_WIDTH-1:0].
- `q` and `r` change only on the DONE-entry edge (or reset). They are stable at all other times, including throughout RUN.
- `start` while in RUN is ignored; there is no queueing.
- Width rule: `rem` before each shift is < divisor ≤ 7, so Y_WIDTH+1 bits never overflow. The result always satisfies q·y + r = p with r < y for y ≠ 0.
- y = 0 without the macro: the natural algorithm result, q = all ones (63), r = p[Y_WIDTH-1:0].
- Reset values: `q`=0, `r`=0, `busy`=0, `rdy`=0, `dz`=0; state IDLE.

## Timing
- Start accepted at edge N, so `busy`=1 after N.
- Iteration steps run on edges N+1 … N+P_WIDTH.
- At edge N+P_WIDTH (6): `busy`=0, `rdy`=1, `q`/`r` valid.
- Latency is 6 cycles from the accepting edge. Throughput is one division per 7 cycles with back-to-back `start`.
- `start` held high in DONE: accepted the same cycle `rdy` is seen. `rdy` falls after that edge, and the new division begins immediately.
- `rst` mid-RUN: at the next edge, return to IDLE with all outputs at reset values, and discard the partial result. `rst` dominates a simultaneous `start`.
- Inputs `p`/`y` may change freely after the accepting edge.

## Configuration
- `DIVU_DIV0_EN` defined:
  - `dz` port exists.
  - A start with y = 0 goes IDLE/DONE → DONE in one edge: `q` = all ones, `r` = 0, `dz`=1, `rdy`=1, `busy` never asserts.
  - `dz` clears on the next accepted start or on reset.
- Not defined:
  - no `dz` port;
  - y = 0 runs the full 6-cycle iteration, giving q = 63 and r = p[2:0].

## Test plan
- Reset, then p=45, y=5, start pulse → `rdy` at +6 cycles, q=9, r=0; `busy` high for exactly 6 cycles.
- p=50, y=3 → q=16, r=2. p=5, y=7 → q=0, r=5. p=63, y=1 → q=63, r=0.
- Start p=50, y=3, then pulse start with p=7, y=7 during RUN → start ignored, result q=16, r=2.
- Back-to-back: hold `start` with a new operand pair in DONE → second result after 6 more cycles, and `q`/`r` hold the first result until then.
- Assert `rst` at cycle 3 of RUN → next edge: `busy`=0, `rdy`=0, q=0, r=0; a subsequent start completes normally.
- y=0, p=45:
  - without the macro → after 6 cycles q=63, r=5;
  - with `DIVU_DIV0_EN` → after 1 edge `dz`=1, q=63, r=0, `busy` never high.

Source files
------------

// File: rtl/divu_p6y3.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/busy/rdy handshake.
// Optional macro DIVU_DIV0_EN adds the dz port and a one-edge divide-by-zero shortcut.
module divu_p6y3 #(
   parameter int P_WIDTH = 6,
   parameter int Y_WIDTH = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [P_WIDTH-1:0] p,
   input  logic [Y_WIDTH-1:0] y,
   output logic [P_WIDTH-1:0] q,
   output logic [Y_WIDTH-1:0] r,
   output logic               busy,
`ifdef DIVU_DIV0_EN
   output logic               rdy,
   output logic               dz
`else
   output logic               rdy
`endif
);

   localparam int CNT_W = $clog2(P_WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic [P_WIDTH-1:0]   dvd;
   logic [Y_WIDTH-1:0]   dvs;
   logic [Y_WIDTH:0]     rem;
   logic [P_WIDTH-1:0]   quo;

   logic [Y_WIDTH:0]     rem_sh;
   logic [Y_WIDTH:0]     rem_nx;
   logic                 qbit;

   // One restoring step: bring in the next dividend bit, subtract if it fits.
   always_comb begin
      rem_sh = {rem[Y_WIDTH-1:0], dvd[P_WIDTH-1]};
      rem_nx = rem_sh;
      qbit   = 1'b0;
      if (rem_sh >= {1'b0, dvs}) begin
         rem_nx = rem_sh - {1'b0, dvs};
         qbit   = 1'b1;
      end
   end

   // Operand/working registers carry no reset; only control and visible outputs do.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         rdy   <= 1'b0;
         q     <= '0;
         r     <= '0;
`ifdef DIVU_DIV0_EN
         dz    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
`ifdef DIVU_DIV0_EN
                  if (y == '0) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     rdy   <= 1'b1;
                     dz    <= 1'b1;
                     q     <= '1;
                     r     <= '0;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                     rdy   <= 1'b0;
                     dz    <= 1'b0;
                     cnt   <= '0;
                     dvd   <= p;
                     dvs   <= y;
                     rem   <= '0;
                  end
`else
                  state <= RUN;
                  busy  <= 1'b1;
                  rdy   <= 1'b0;
                  cnt   <= '0;
                  dvd   <= p;
                  dvs   <= y;
                  rem   <= '0;
`endif
               end
            end
            RUN: begin
               dvd <= dvd << 1;
               rem <= rem_nx;
               quo <= {quo[P_WIDTH-2:0], qbit};
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(P_WIDTH - 1)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  rdy   <= 1'b1;
                  q     <= {quo[P_WIDTH-2:0], qbit};
                  r     <= rem_nx[Y_WIDTH-1:0];
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               rdy   <= 1'b0;
            end
         endcase
      end
   end

endmodule
